// File: rtl/dbus_sram_resp.sv
// -----------------------------------------------------------------------------
// dbus_sram_resp
//   Data-bus responder for the ezpipe core. It answers one dbus_rd/dbus_wr
//   request at a time from a word-organised SRAM. It inserts WAIT_CYCLES
//   programmable wait states and emits a one-cycle dbus_data_ready pulse per
//   transaction.
//
//   FSM:  IDLE -> WAIT (WAIT_CYCLES>0) or ACCESS (WAIT_CYCLES=0) -> ACCESS
//         -> RESP -> IDLE
//   One transaction takes WAIT_CYCLES+3 cycles.
//
// Parameters
//   DEPTH        memory size in 32-bit words (power of two, >= 2)
//   WAIT_CYCLES  extra cycles between request capture and access (0..15)
//
// Ports
//   clk              clock, all state updates on posedge
//   reset            asynchronous, active-low reset
//   dbus_addr        byte address (bits [1:0] ignored for indexing)
//   dbus_data_wr     write data
//   dbus_be          write byte enables, bit i -> byte lane i
//   dbus_rd          read request, held until ready
//   dbus_wr          write request, held until ready (wins over dbus_rd)
//   dbus_data_rd     read data, valid with dbus_data_ready, holds between reads
//   dbus_data_ready  one-cycle transaction-complete pulse
//   dbus_err         (DBUS_SRAM_RESP_ERR_EN only) misaligned/out-of-range flag,
//                    asserted only together with dbus_data_ready
//
// Configuration macro
//   DBUS_SRAM_RESP_ERR_EN  adds dbus_err. A misaligned access becomes an
//                          error: writes are dropped and reads return 0.
// -----------------------------------------------------------------------------
module dbus_sram_resp #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dbus_addr,
    input  logic [31:0] dbus_data_wr,
    input  logic [3:0]  dbus_be,
    input  logic        dbus_rd,
    input  logic        dbus_wr,
    output logic [31:0] dbus_data_rd,
`ifdef DBUS_SRAM_RESP_ERR_EN
    output logic        dbus_err,
`endif
    output logic        dbus_data_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("dbus_sram_resp: WAIT_CYCLES must be in 0..15");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dbus_sram_resp: DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t      state, state_next;
    logic [3:0]  wait_cnt;
    logic [29:0] req_word;      // captured addr[31:2]
    logic [31:0] req_data;
    logic [3:0]  req_be;
    logic        req_wr;
    logic        req_mis;       // captured addr[1:0] != 0
    logic        req_bad;       // access must not touch memory
    logic [AW-1:0] req_idx;
    logic        req_oor;

    logic [31:0] mem [DEPTH];

    assign req_idx = req_word[AW-1:0];
    // Any set bit above the index field means addr >= 4*DEPTH.
    assign req_oor = (req_word >> AW) != 30'd0;

`ifdef DBUS_SRAM_RESP_ERR_EN
    assign req_bad = req_oor | req_mis;
`else
    assign req_bad = req_oor;
    // Without the error feature the misalignment flag has no consumer.
    logic unused_mis;
    assign unused_mis = req_mis;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // flop samples its pre-edge inputs regardless of statement order.
            state <= state_next;
        end
    end

    // Next-state and outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave a value unassigned and infer a latch.
        state_next      = state;
        dbus_data_ready = 1'b0;
`ifdef DBUS_SRAM_RESP_ERR_EN
        dbus_err        = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (dbus_rd || dbus_wr) begin
                    state_next = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) state_next = ST_ACCESS;
            end
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP: begin
                // New requests are only sampled again once back in IDLE.
                state_next      = ST_IDLE;
                dbus_data_ready = 1'b1;
`ifdef DBUS_SRAM_RESP_ERR_EN
                dbus_err        = req_bad;
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request capture, wait counter and read-data register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt     <= 4'd0;
            req_word     <= 30'd0;
            req_data     <= 32'd0;
            req_be       <= 4'd0;
            req_wr       <= 1'b0;
            req_mis      <= 1'b0;
            dbus_data_rd <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dbus_rd || dbus_wr) begin
                        req_word <= dbus_addr[31:2];
                        req_mis  <= (dbus_addr[1:0] != 2'b00);
                        req_data <= dbus_data_wr;
                        req_be   <= dbus_be;
                        req_wr   <= dbus_wr;   // rd+wr together is a write
                        wait_cnt <= WAIT_INIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                end
                ST_ACCESS: begin
                    if (!req_wr) dbus_data_rd <= req_bad ? 32'd0 : mem[req_idx];
                end
                default: ;
            endcase
        end
    end

    // SRAM write port with byte-lane merge.
    // NOTE: the memory array has no reset. SRAM contents are undefined after
    // power-up. A reset mid-transaction forces IDLE, so no write occurs.
    always_ff @(posedge clk) begin
        if (state == ST_ACCESS && req_wr && !req_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (req_be[i]) mem[req_idx][8*i +: 8] <= req_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dbus_sram_resp.sv
// -----------------------------------------------------------------------------
// tb_dbus_sram_resp
//   Directed testbench for dbus_sram_resp with DEPTH=64 and WAIT_CYCLES=1.
//   4*DEPTH is 0x100. Expected values are hand-computed constants.
//
//   Latency: let N be the capture edge. The responder passes through WAIT
//   (WAIT_CYCLES edges) and ACCESS, so dbus_data_ready is seen after edge
//   N+WAIT_CYCLES+1. That is the cycle numbered N+WAIT_CYCLES+2, counting the
//   cycle that ends at edge k as cycle k.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dbus_sram_resp;

    localparam int DEPTH = 64;
    localparam int WAITC = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_data_wr;
    logic [3:0]  dbus_be;
    logic        dbus_rd;
    logic        dbus_wr;
    logic [31:0] dbus_data_rd;
    logic        dbus_data_ready;
    logic        err_obs;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dbus_sram_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk             (clk),
        .reset           (reset),
        .dbus_addr       (dbus_addr),
        .dbus_data_wr    (dbus_data_wr),
        .dbus_be         (dbus_be),
        .dbus_rd         (dbus_rd),
        .dbus_wr         (dbus_wr),
        .dbus_data_rd    (dbus_data_rd),
`ifdef DBUS_SRAM_RESP_ERR_EN
        .dbus_err        (err_obs),
`endif
        .dbus_data_ready (dbus_data_ready)
    );

`ifndef DBUS_SRAM_RESP_ERR_EN
    assign err_obs = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Runs one transaction. Inputs are scrambled right after the capture edge
    // to show that only the captured request matters.
    task automatic do_txn(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be,
                          output logic [31:0] rdata, output logic err);
        int lat;
        @(negedge clk);
        dbus_rd = rd; dbus_wr = wr; dbus_addr = addr; dbus_data_wr = data; dbus_be = be;
        @(posedge clk); #1;
        dbus_addr = 32'hFFFF_FFF0; dbus_data_wr = ~data; dbus_be = 4'hF;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (dbus_data_ready) break;
        end
        check({tag, "_latency"}, 32'(lat), 32'(WAITC + 1));
        rdata = dbus_data_rd;
        err   = err_obs;
        dbus_rd = 1'b0; dbus_wr = 1'b0;
        @(posedge clk); #1;
        check({tag, "_one_pulse"}, {31'd0, dbus_data_ready}, 32'd0);
    endtask

    logic [31:0] rd_v;
    logic        err_v;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        dbus_rd = 1'b0; dbus_wr = 1'b0; dbus_addr = 32'd0; dbus_data_wr = 32'd0; dbus_be = 4'd0;
        #1;
        check("rst_ready", {31'd0, dbus_data_ready}, 32'd0);
        check("rst_rdata", dbus_data_rd, 32'd0);
`ifdef DBUS_SRAM_RESP_ERR_EN
        check("rst_err", {31'd0, err_obs}, 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;

        // 1: reset during WAIT of a write drops it
        do_txn("t1_init_wr", 1'b0, 1'b1, 32'h10, 32'h1111_1111, 4'hF, rd_v, err_v);
        do_txn("t1_init_rd", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rd_v, err_v);
        check("t1_init_rd_data", rd_v, 32'h1111_1111);
        @(negedge clk);
        dbus_wr = 1'b1; dbus_addr = 32'h10; dbus_data_wr = 32'hDEAD_BEEF; dbus_be = 4'hF;
        @(posedge clk); #1;           // captured, now in WAIT
        reset = 1'b0;
        #1;
        check("t1_rst_rdata", dbus_data_rd, 32'd0);
        dbus_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("t1_rst_no_ready", {31'd0, dbus_data_ready}, 32'd0);
        end
        @(negedge clk); reset = 1'b1;
        do_txn("t1_rd", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rd_v, err_v);
        check("t1_old_value", rd_v, 32'h1111_1111);

        // 2: full-word write then read back
        do_txn("t2_wr", 1'b0, 1'b1, 32'h40, 32'h1234_5678, 4'hF, rd_v, err_v);
        do_txn("t2_rd", 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, rd_v, err_v);
        check("t2_data", rd_v, 32'h1234_5678);

        // 3: byte-lane merge; writes leave dbus_data_rd alone
        do_txn("t3_clr", 1'b0, 1'b1, 32'h8, 32'h0, 4'hF, rd_v, err_v);
        do_txn("t3_wr", 1'b0, 1'b1, 32'h8, 32'hAABB_CCDD, 4'b0101, rd_v, err_v);
        check("t3_wr_keeps_rd", rd_v, 32'h1234_5678);
        do_txn("t3_rd", 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, rd_v, err_v);
        check("t3_merge", rd_v, 32'h00BB_00DD);

        // 4: rd and wr together act as a write
        do_txn("t4_rdwr", 1'b1, 1'b1, 32'h4, 32'h5, 4'hF, rd_v, err_v);
        check("t4_rd_unchanged", rd_v, 32'h00BB_00DD);
        do_txn("t4_rd", 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, rd_v, err_v);
        check("t4_mem", rd_v, 32'h5);

        // 5: out-of-range and misaligned accesses
        do_txn("t5_oor_rd", 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, rd_v, err_v);
        check("t5_oor_rd_zero", rd_v, 32'd0);
`ifdef DBUS_SRAM_RESP_ERR_EN
        check("t5_oor_rd_err", {31'd0, err_v}, 32'd1);
`endif
        do_txn("t5_w0", 1'b0, 1'b1, 32'h0, 32'h0BAD_0000, 4'hF, rd_v, err_v);
        do_txn("t5_oor_wr", 1'b0, 1'b1, 32'h100, 32'hCAFE_F00D, 4'hF, rd_v, err_v);
        do_txn("t5_rd0", 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, rd_v, err_v);
        check("t5_no_alias", rd_v, 32'h0BAD_0000);
        do_txn("t5_mis_wr", 1'b0, 1'b1, 32'h6, 32'h77, 4'hF, rd_v, err_v);
`ifdef DBUS_SRAM_RESP_ERR_EN
        check("t5_mis_err", {31'd0, err_v}, 32'd1);
        do_txn("t5_rd4", 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, rd_v, err_v);
        check("t5_mis_unchanged", rd_v, 32'h5);
        check("t5_aligned_no_err", {31'd0, err_v}, 32'd0);
`else
        do_txn("t5_rd4", 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, rd_v, err_v);
        check("t5_mis_uses_word", rd_v, 32'h77);
`endif

        // 6: rd held across three transactions
        begin
            int pulses = 0;
            int edges  = 0;
            int p[3];
            p = '{0, 0, 0};
            @(negedge clk);
            dbus_rd = 1'b1; dbus_wr = 1'b0; dbus_addr = 32'h40; dbus_be = 4'h0;
            while (pulses < 3 && edges < 60) begin
                @(posedge clk); #1;
                edges++;
                if (dbus_data_ready) begin
                    p[pulses] = edges;
                    pulses++;
                end
            end
            dbus_rd = 1'b0;
            check("t6_first", 32'(p[0]), 32'(WAITC + 2));
            check("t6_gap1", 32'(p[1] - p[0]), 32'(WAITC + 3));
            check("t6_gap2", 32'(p[2] - p[1]), 32'(WAITC + 3));
            check("t6_data", dbus_data_rd, 32'h1234_5678);
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                if (dbus_data_ready) pulses++;
            end
            check("t6_pulses", 32'(pulses), 32'd3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
